// File: rtl/fifo_p3o1_pkg.sv
// Shared defaults, write-count encodings and configuration check for fifo_p3o1.
// No logic of its own; constants only.
// No flow control here; consumers handle backpressure.
package fifo_p3o1_pkg;

    localparam int DEF_NUM_WDATA     = 3;
    localparam int DEF_DAT_WIDTH     = 8;
    localparam int DEF_FF_DEPTH      = 8;
    localparam int DEF_FF_ADDR_WIDTH = 3;

    // Encoding of wr_num: how many packed words in wr_data are meaningful.
    localparam logic [1:0] WNUM_NONE = 2'd0;
    localparam logic [1:0] WNUM_1    = 2'd1;
    localparam logic [1:0] WNUM_2    = 2'd2;
    localparam logic [1:0] WNUM_3    = 2'd3;

    // Depth must be a power of two matching the address width, and must hold
    // at least one full burst plus one word.
    function automatic bit depth_ok(input int depth, input int addr_width);
        return (depth == (1 << addr_width)) && (depth >= 4);
    endfunction

endpackage

// File: rtl/fifo_p3o1_if.sv
// Bundle of the write/read handshake signals of fifo_p3o1.
// Error flags err_ovf/err_udf exist only when FIFO_P3O1_ERR_FLAG_EN is defined.
// master = producer/consumer side, slave = FIFO side.
interface fifo_p3o1_if import fifo_p3o1_pkg::*; #(
    parameter int NUM_WDATA     = DEF_NUM_WDATA,
    parameter int DAT_WIDTH     = DEF_DAT_WIDTH,
    parameter int FF_ADDR_WIDTH = DEF_FF_ADDR_WIDTH
);
    logic                           wr_req;
    logic [1:0]                     wr_num;
    logic [DAT_WIDTH*NUM_WDATA-1:0] wr_data;
    logic                           rd_req;
    logic [DAT_WIDTH-1:0]           rd_data;
    logic                           rd_data_val;
    logic [FF_ADDR_WIDTH:0]         data_counter;
    logic                           full;
    logic                           empty;
`ifdef FIFO_P3O1_ERR_FLAG_EN
    logic                           err_ovf;
    logic                           err_udf;
`endif

    modport master (
        output wr_req, wr_num, wr_data, rd_req,
        input  rd_data, rd_data_val, data_counter, full, empty
`ifdef FIFO_P3O1_ERR_FLAG_EN
        , input err_ovf, err_udf
`endif
    );

    modport slave (
        input  wr_req, wr_num, wr_data, rd_req,
        output rd_data, rd_data_val, data_counter, full, empty
`ifdef FIFO_P3O1_ERR_FLAG_EN
        , output err_ovf, err_udf
`endif
    );

endinterface

// File: rtl/fifo_mem_3w1r.sv
// Register array with three write ports and one asynchronous read port.
// Writes land at the rising edge; read is combinational from the array.
// No backpressure; the caller guarantees the three write addresses differ.
module fifo_mem_3w1r #(
    parameter int DAT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                                clk,
    input  logic [2:0]                          we,
    input  logic [2:0][ADDR_WIDTH-1:0]          waddr,
    input  logic [2:0][DAT_WIDTH-1:0]           wdata,
    input  logic [ADDR_WIDTH-1:0]               raddr,
    output logic [DAT_WIDTH-1:0]                rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0][DAT_WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][DAT_WIDTH-1:0] mem_d;

    // Merge the enabled write ports into the next array image.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < 3; p++) begin
            if (we[p]) begin
                mem_d[waddr[p]] = wdata[p];
            end
        end
    end

    // Storage is deliberately not reset; only written entries are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_p3o1.sv
// Width-converting FIFO: up to 3 words per write, 1 word per read, oldest first.
// Read latency 1 (registered rd_data); write visible to reads the next cycle.
// Writes that do not fit are dropped whole; FIFO_P3O1_ERR_FLAG_EN adds sticky err_ovf/err_udf.
module fifo_p3o1 import fifo_p3o1_pkg::*; #(
    parameter int NUM_WDATA     = DEF_NUM_WDATA,
    parameter int DAT_WIDTH     = DEF_DAT_WIDTH,
    parameter int FF_DEPTH      = DEF_FF_DEPTH,
    parameter int FF_ADDR_WIDTH = DEF_FF_ADDR_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    fifo_p3o1_if.slave bus
);
    localparam int AW = FF_ADDR_WIDTH;
    localparam int CW = FF_ADDR_WIDTH + 1;

    if (!depth_ok(FF_DEPTH, FF_ADDR_WIDTH) || NUM_WDATA != 3) begin : g_bad_cfg
        $error("fifo_p3o1: unsupported depth/address-width/word-count combination");
    end

    logic [CW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DAT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_data_val_q, rd_data_val_d;

    logic [CW-1:0]        free;
    logic [CW-1:0]        wr_num_ext;
    logic                 wr_enb;
    logic                 rd_enb;
    logic                 empty_w;

    logic [2:0]                  mem_we;
    logic [2:0][AW-1:0]          mem_waddr;
    logic [2:0][DAT_WIDTH-1:0]   mem_wdata;
    logic [DAT_WIDTH-1:0]        mem_rdata;

    // Accept decisions from pre-edge occupancy; a short write is all-or-nothing.
    always_comb begin
        free       = CW'(FF_DEPTH) - cnt_q;
        wr_num_ext = CW'(bus.wr_num);
        empty_w    = (cnt_q == '0);
        wr_enb     = bus.wr_req && (bus.wr_num != WNUM_NONE) && (free >= wr_num_ext);
        rd_enb     = bus.rd_req && !empty_w;
    end

    // Fan the burst out to consecutive (wrapping) memory slots.
    always_comb begin
        mem_we    = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            mem_we[i]    = wr_enb && (i < int'(bus.wr_num));
            mem_waddr[i] = wr_ptr_q[AW-1:0] + AW'(i);
            mem_wdata[i] = bus.wr_data[i*DAT_WIDTH +: DAT_WIDTH];
        end
    end

    fifo_mem_3w1r #(
        .DAT_WIDTH  (DAT_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Pointer, occupancy and read-output next state; rd_data is zero when idle.
    always_comb begin
        wr_ptr_d      = wr_ptr_q + (wr_enb ? wr_num_ext : '0);
        rd_ptr_d      = rd_ptr_q + (rd_enb ? CW'(1) : '0);
        cnt_d         = cnt_q + (wr_enb ? wr_num_ext : '0) - (rd_enb ? CW'(1) : '0);
        rd_data_val_d = rd_enb;
        rd_data_d     = rd_enb ? mem_rdata : '0;
    end

    // Control state; the async reset also discards any in-flight transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            rd_data_q     <= '0;
            rd_data_val_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            rd_data_q     <= rd_data_d;
            rd_data_val_q <= rd_data_val_d;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_data_val  = rd_data_val_q;
    assign bus.data_counter = cnt_q;
    assign bus.empty        = empty_w;
    // Full means a maximum-size burst might not fit, not that storage is exhausted.
    assign bus.full         = (free < CW'(NUM_WDATA));

`ifdef FIFO_P3O1_ERR_FLAG_EN
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;

    // Sticky flags for dropped writes and reads against an empty FIFO.
    always_comb begin
        err_ovf_d = err_ovf_q | (bus.wr_req && (bus.wr_num != WNUM_NONE) && !wr_enb);
        err_udf_d = err_udf_q | (bus.rd_req && empty_w);
    end

    // Flags clear only through reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign bus.err_ovf = err_ovf_q;
    assign bus.err_udf = err_udf_q;
`endif

endmodule

// File: tb/tb_fifo_p3o1.sv
// Directed bench for fifo_p3o1: reset, ordering, fill/drop, wrap, concurrency, reset mid-burst.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-computed constants in each scenario task.
module tb_fifo_p3o1;
    import fifo_p3o1_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fifo_p3o1_if bus ();

    fifo_p3o1 dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [1:0] num, input logic [23:0] dat, input logic rd);
        bus.wr_req  = wr;
        bus.wr_num  = num;
        bus.wr_data = dat;
        bus.rd_req  = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, WNUM_NONE, 24'h0, 1'b0);
        #2;
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", bus.rd_data); end
        checks++; if (bus.rd_data_val !== 1'b0) begin errors++; $display("FAIL reset_rd_val got %b exp 0", bus.rd_data_val); end
        checks++; if (bus.data_counter !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.data_counter); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
`ifdef FIFO_P3O1_ERR_FLAG_EN
        checks++; if (bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", bus.err_ovf, bus.err_udf); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] e;
        drive(1'b1, WNUM_3, 24'h332211, 1'b0);
        cyc();
        checks++; if (bus.data_counter !== 4'd3) begin errors++; $display("FAIL basic_wr_cnt got %0d exp 3", bus.data_counter); end
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL basic_wr_empty got %b exp 0", bus.empty); end
        checks++; if (bus.rd_data_val !== 1'b0) begin errors++; $display("FAIL basic_wr_val got %b exp 0", bus.rd_data_val); end
        drive(1'b0, WNUM_NONE, 24'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            e = 8'(8'h11 * (k + 1));
            checks++; if (bus.rd_data !== e) begin errors++; $display("FAIL basic_rd%0d data got %h exp %h", k, bus.rd_data, e); end
            checks++; if (bus.rd_data_val !== 1'b1) begin errors++; $display("FAIL basic_rd%0d val got %b exp 1", k, bus.rd_data_val); end
            checks++; if (bus.data_counter !== 4'(2 - k)) begin errors++; $display("FAIL basic_rd%0d cnt got %0d exp %0d", k, bus.data_counter, 2 - k); end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL basic_end_empty got %b exp 1", bus.empty); end
        drive(1'b0, WNUM_NONE, 24'h0, 1'b0);
        cyc();
        checks++; if (bus.rd_data_val !== 1'b0 || bus.rd_data !== 8'h00) begin errors++; $display("FAIL basic_idle got val %b data %h exp 0 00", bus.rd_data_val, bus.rd_data); end
    endtask

    task automatic test_fill();
        drive(1'b1, WNUM_3, 24'h030201, 1'b0);
        cyc();
        checks++; if (bus.data_counter !== 4'd3 || bus.full !== 1'b0) begin errors++; $display("FAIL fill_w1 got cnt %0d full %b exp 3 0", bus.data_counter, bus.full); end
        drive(1'b1, WNUM_3, 24'h060504, 1'b0);
        cyc();
        checks++; if (bus.data_counter !== 4'd6 || bus.full !== 1'b1) begin errors++; $display("FAIL fill_w2 got cnt %0d full %b exp 6 1", bus.data_counter, bus.full); end
        drive(1'b1, WNUM_2, 24'hFF0807, 1'b0);
        cyc();
        checks++; if (bus.data_counter !== 4'd8 || bus.full !== 1'b1) begin errors++; $display("FAIL fill_w3 got cnt %0d full %b exp 8 1", bus.data_counter, bus.full); end
        drive(1'b1, WNUM_1, 24'h0000AA, 1'b0);
        cyc();
        checks++; if (bus.data_counter !== 4'd8) begin errors++; $display("FAIL fill_drop cnt got %0d exp 8", bus.data_counter); end
`ifdef FIFO_P3O1_ERR_FLAG_EN
        checks++; if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL fill_err_ovf got %b exp 1", bus.err_ovf); end
`endif
        drive(1'b0, WNUM_NONE, 24'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cyc();
            checks++; if (bus.rd_data !== 8'(k + 1) || bus.rd_data_val !== 1'b1) begin errors++; $display("FAIL fill_rd%0d got %h val %b exp %h 1", k, bus.rd_data, bus.rd_data_val, 8'(k + 1)); end
        end
        checks++; if (bus.data_counter !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL fill_drained got cnt %0d empty %b exp 0 1", bus.data_counter, bus.empty); end
        drive(1'b0, WNUM_NONE, 24'h0, 1'b0);
        cyc();
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        for (int r = 0; r < 4; r++) begin
            b = 8'h40 + 8'(3 * r);
            drive(1'b1, WNUM_3, {b + 8'd2, b + 8'd1, b}, 1'b0);
            cyc();
            drive(1'b0, WNUM_NONE, 24'h0, 1'b1);
            for (int k = 0; k < 3; k++) begin
                cyc();
                checks++; if (bus.rd_data !== b + 8'(k)) begin errors++; $display("FAIL wrap_r%0d_k%0d got %h exp %h", r, k, bus.rd_data, b + 8'(k)); end
            end
        end
        drive(1'b0, WNUM_NONE, 24'h0, 1'b0);
        cyc();
    endtask

    task automatic test_simul();
        drive(1'b1, WNUM_3, 24'h535251, 1'b0);
        cyc();
        drive(1'b1, WNUM_1, 24'h000054, 1'b0);
        cyc();
        checks++; if (bus.data_counter !== 4'd4) begin errors++; $display("FAIL simul_pre cnt got %0d exp 4", bus.data_counter); end
        drive(1'b1, WNUM_2, 24'h005655, 1'b1);
        cyc();
        checks++; if (bus.data_counter !== 4'd5) begin errors++; $display("FAIL simul_cnt got %0d exp 5", bus.data_counter); end
        checks++; if (bus.rd_data !== 8'h51 || bus.rd_data_val !== 1'b1) begin errors++; $display("FAIL simul_rd got %h val %b exp 51 1", bus.rd_data, bus.rd_data_val); end
        drive(1'b0, WNUM_NONE, 24'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++; if (bus.rd_data !== 8'h52 + 8'(k)) begin errors++; $display("FAIL simul_drain%0d got %h exp %h", k, bus.rd_data, 8'h52 + 8'(k)); end
        end
        checks++; if (bus.data_counter !== 4'd0) begin errors++; $display("FAIL simul_end cnt got %0d exp 0", bus.data_counter); end
        drive(1'b0, WNUM_NONE, 24'h0, 1'b0);
        cyc();
    endtask

    task automatic test_empty_read();
        drive(1'b0, WNUM_NONE, 24'h0, 1'b1);
        cyc();
        checks++; if (bus.rd_data_val !== 1'b0 || bus.rd_data !== 8'h00) begin errors++; $display("FAIL empty_rd got val %b data %h exp 0 00", bus.rd_data_val, bus.rd_data); end
        checks++; if (bus.data_counter !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL empty_rd_state got cnt %0d empty %b exp 0 1", bus.data_counter, bus.empty); end
`ifdef FIFO_P3O1_ERR_FLAG_EN
        checks++; if (bus.err_udf !== 1'b1) begin errors++; $display("FAIL empty_err_udf got %b exp 1", bus.err_udf); end
`endif
        drive(1'b0, WNUM_NONE, 24'h0, 1'b0);
        cyc();
    endtask

    task automatic test_first_write_read();
        drive(1'b1, WNUM_1, 24'h000077, 1'b1);
        cyc();
        checks++; if (bus.rd_data_val !== 1'b0 || bus.data_counter !== 4'd1) begin errors++; $display("FAIL fwr_same got val %b cnt %0d exp 0 1", bus.rd_data_val, bus.data_counter); end
        drive(1'b0, WNUM_NONE, 24'h0, 1'b1);
        cyc();
        checks++; if (bus.rd_data !== 8'h77 || bus.rd_data_val !== 1'b1 || bus.data_counter !== 4'd0) begin errors++; $display("FAIL fwr_next got %h val %b cnt %0d exp 77 1 0", bus.rd_data, bus.rd_data_val, bus.data_counter); end
        drive(1'b0, WNUM_NONE, 24'h0, 1'b0);
        cyc();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, WNUM_3, 24'h636261, 1'b0);
        cyc();
        drive(1'b1, WNUM_3, 24'h666564, 1'b1);
        cyc();
        checks++; if (bus.rd_data !== 8'h61 || bus.rd_data_val !== 1'b1 || bus.data_counter !== 4'd5) begin errors++; $display("FAIL rstmid_pre got %h val %b cnt %0d exp 61 1 5", bus.rd_data, bus.rd_data_val, bus.data_counter); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rd_data !== 8'h00 || bus.rd_data_val !== 1'b0) begin errors++; $display("FAIL rstmid_rd got %h val %b exp 00 0", bus.rd_data, bus.rd_data_val); end
        checks++; if (bus.data_counter !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL rstmid_flags got cnt %0d empty %b full %b exp 0 1 0", bus.data_counter, bus.empty, bus.full); end
`ifdef FIFO_P3O1_ERR_FLAG_EN
        checks++; if (bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b%b exp 00", bus.err_ovf, bus.err_udf); end
`endif
        drive(1'b0, WNUM_NONE, 24'h0, 1'b0);
        rst_n = 1'b1;
        cyc();
        checks++; if (bus.data_counter !== 4'd0 || bus.rd_data_val !== 1'b0) begin errors++; $display("FAIL rstmid_after got cnt %0d val %b exp 0 0", bus.data_counter, bus.rd_data_val); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_simul();
        test_empty_read();
        test_first_write_read();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
